int_regfile_mp: RTL and testbench

INT_REGFILE_MP -- requirements
Module: int_regfile_mp

---
 rtl/int_rf_pkg.sv | 22 ++
 rtl/int_rf_scoreboard.sv | 48 ++++
 rtl/int_regfile_mp.sv | 144 ++++++++++++++
 tb/tb_int_regfile_mp.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/int_rf_pkg.sv
// int_rf_pkg: shared constants for the multi-port integer register file.
//   - default data width
//   - CSR reset values
//   - exc_cause_i bit positions that keep mepc at the faulting PC
//     (no +4 adjust)
package int_rf_pkg;

    localparam int XLEN_DEF = 32;

    // CSR reset values. These are cast to XLEN at the point of use.
    localparam int MEPC_RST   = 0;
    localparam int MTVAL_RST  = 0;
    localparam int MCAUSE_RST = 0;
    localparam int MPP_RST    = 0;
    localparam int MPRIV_RST  = 1;

    // Causes with any of these bits set report the faulting PC itself.
    localparam int CAUSE_KEEP_PC_B0 = 12;
    localparam int CAUSE_KEEP_PC_B1 = 13;
    localparam int CAUSE_KEEP_PC_B2 = 15;

endpackage

// File: rtl/int_rf_scoreboard.sv
// int_rf_scoreboard: one pending bit per architectural register.
// Ports:
//   clk_i, rsn_i        clock and async active-low reset
//   wr_en_i, wr_addr_i  GPR write ports; a write clears the pending bit
//   busy_set_i/addr_i   decode marks a destination as pending
//                       (set wins over a clear to the same address)
//   flush_i             clears every pending bit (exception)
//   busy_o              pending bits; bit 0 is always 0
module int_rf_scoreboard
    import int_rf_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int NWR   = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic              clk_i,
    input  logic              rsn_i,
    input  logic [NWR-1:0]    wr_en_i,
    input  logic [NWR*AW-1:0] wr_addr_i,
    input  logic              busy_set_i,
    input  logic [AW-1:0]     busy_addr_i,
    input  logic              flush_i,
    output logic [NREGS-1:0]  busy_o
);

    logic [NWR-1:0][AW-1:0] wa;
    logic [NREGS-1:0]       busy_d, busy_q;

    assign wa = wr_addr_i;

    always_comb begin
        busy_d = busy_q;
        for (int p = 0; p < NWR; p++)
            if (wr_en_i[p]) busy_d[wa[p]] = 1'b0;
        // The set is applied after the clears so that it wins.
        if (busy_set_i && busy_addr_i != '0) busy_d[busy_addr_i] = 1'b1;
        if (flush_i) busy_d = '0;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/int_regfile_mp.sv
// int_regfile_mp: multi-port integer register file with a scoreboard and
// machine-mode trap CSRs.
//
// Optional feature: define INT_RF_BYPASS_EN to forward same-cycle write
// data to a matching read.
//
// Ports:
//   clk_i, rsn_i            clock and async active-low reset
//   rd_addr_i / rd_data_o   NRD combinational read ports (packed)
//   wr_en_i/addr_i/data_i   NWR write ports; the highest index wins a conflict
//   busy_set_i/addr_i       scoreboard set; busy_o holds the pending bits
//   exc_*                   exception capture (mepc/mtval/mcause, privilege
//                           push, scoreboard flush)
//   mret_i                  pops the privilege level
//   priv_wr_*               direct privilege write (lowest priority)
//   mepc_o, mtval_o, mcause_o, mpriv_o   CSR values
module int_regfile_mp
    import int_rf_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                clk_i,
    input  logic                rsn_i,
    input  logic [NRD*AW-1:0]   rd_addr_i,
    output logic [NRD*XLEN-1:0] rd_data_o,
    input  logic [NWR-1:0]      wr_en_i,
    input  logic [NWR*AW-1:0]   wr_addr_i,
    input  logic [NWR*XLEN-1:0] wr_data_i,
    input  logic                busy_set_i,
    input  logic [AW-1:0]       busy_addr_i,
    output logic [NREGS-1:0]    busy_o,
    input  logic                exc_en_i,
    input  logic [XLEN-1:0]     exc_pc_i,
    input  logic [XLEN-1:0]     exc_tval_i,
    input  logic [XLEN-1:0]     exc_cause_i,
    input  logic                mret_i,
    input  logic                priv_wr_en_i,
    input  logic [XLEN-1:0]     priv_wr_data_i,
    output logic [XLEN-1:0]     mepc_o,
    output logic [XLEN-1:0]     mtval_o,
    output logic [XLEN-1:0]     mcause_o,
    output logic [XLEN-1:0]     mpriv_o
);

    logic [NRD-1:0][AW-1:0]     ra;
    logic [NRD-1:0][XLEN-1:0]   rd;
    logic [NWR-1:0][AW-1:0]     wa;
    logic [NWR-1:0][XLEN-1:0]   wd;
    logic [NREGS-1:0][XLEN-1:0] regs_d, regs_q;
    logic [XLEN-1:0] mepc_d, mepc_q, mtval_d, mtval_q, mcause_d, mcause_q;
    logic [XLEN-1:0] mpp_d, mpp_q, mpriv_d, mpriv_q;
    logic            keep_pc;

    assign ra = rd_addr_i;
    assign wa = wr_addr_i;
    assign wd = wr_data_i;

    // GPR writes: ascending port order, so the highest port is applied last.
    // Exceptions do not gate these writes.
    always_comb begin
        regs_d = regs_q;
        for (int p = 0; p < NWR; p++)
            if (wr_en_i[p] && wa[p] != '0) regs_d[wa[p]] = wd[p];
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) regs_q <= '0;
        else        regs_q <= regs_d;
    end

    always_comb begin
        rd = '0;
        for (int r = 0; r < NRD; r++) begin
            if (ra[r] != '0) rd[r] = regs_q[ra[r]];
`ifdef INT_RF_BYPASS_EN
            for (int p = 0; p < NWR; p++)
                if (wr_en_i[p] && wa[p] == ra[r] && ra[r] != '0) rd[r] = wd[p];
`endif
        end
    end

    assign rd_data_o = rd;

    int_rf_scoreboard #(.NREGS(NREGS), .NWR(NWR)) u_sb (
        .clk_i       (clk_i),
        .rsn_i       (rsn_i),
        .wr_en_i     (wr_en_i),
        .wr_addr_i   (wr_addr_i),
        .busy_set_i  (busy_set_i),
        .busy_addr_i (busy_addr_i),
        .flush_i     (exc_en_i),
        .busy_o      (busy_o)
    );

    assign keep_pc = exc_cause_i[CAUSE_KEEP_PC_B0] | exc_cause_i[CAUSE_KEEP_PC_B1]
                   | exc_cause_i[CAUSE_KEEP_PC_B2];

    // Privilege priority: exception, then mret, then direct write.
    always_comb begin
        mepc_d   = mepc_q;
        mtval_d  = mtval_q;
        mcause_d = mcause_q;
        mpp_d    = mpp_q;
        mpriv_d  = mpriv_q;
        if (exc_en_i) begin
            mepc_d   = keep_pc ? exc_pc_i : exc_pc_i + XLEN'(4);
            mtval_d  = exc_tval_i;
            mcause_d = exc_cause_i;
            mpp_d    = mpriv_q;
            mpriv_d  = XLEN'(MPRIV_RST);
        end else if (mret_i) begin
            mpriv_d = mpp_q;
            mpp_d   = '0;
        end else if (priv_wr_en_i) begin
            mpriv_d = priv_wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            mepc_q   <= XLEN'(MEPC_RST);
            mtval_q  <= XLEN'(MTVAL_RST);
            mcause_q <= XLEN'(MCAUSE_RST);
            mpp_q    <= XLEN'(MPP_RST);
            mpriv_q  <= XLEN'(MPRIV_RST);
        end else begin
            mepc_q   <= mepc_d;
            mtval_q  <= mtval_d;
            mcause_q <= mcause_d;
            mpp_q    <= mpp_d;
            mpriv_q  <= mpriv_d;
        end
    end

    assign mepc_o   = mepc_q;
    assign mtval_o  = mtval_q;
    assign mcause_o = mcause_q;
    assign mpriv_o  = mpriv_q;

endmodule

// File: tb/tb_int_regfile_mp.sv
// Directed bench for int_regfile_mp (default parameters).
// Expected values for bypass-dependent reads follow INT_RF_BYPASS_EN.
module tb_int_regfile_mp;

    logic        clk_i = 1'b0;
    logic        rsn_i;
    logic [9:0]  rd_addr_i;
    logic [63:0] rd_data_o;
    logic [1:0]  wr_en_i;
    logic [9:0]  wr_addr_i;
    logic [63:0] wr_data_i;
    logic        busy_set_i;
    logic [4:0]  busy_addr_i;
    logic [31:0] busy_o;
    logic        exc_en_i;
    logic [31:0] exc_pc_i, exc_tval_i, exc_cause_i;
    logic        mret_i, priv_wr_en_i;
    logic [31:0] priv_wr_data_i;
    logic [31:0] mepc_o, mtval_o, mcause_o, mpriv_o;

    int n_chk  = 0;
    int n_fail = 0;

    int_regfile_mp dut (
        .clk_i(clk_i), .rsn_i(rsn_i),
        .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
        .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
        .busy_set_i(busy_set_i), .busy_addr_i(busy_addr_i), .busy_o(busy_o),
        .exc_en_i(exc_en_i), .exc_pc_i(exc_pc_i), .exc_tval_i(exc_tval_i),
        .exc_cause_i(exc_cause_i), .mret_i(mret_i),
        .priv_wr_en_i(priv_wr_en_i), .priv_wr_data_i(priv_wr_data_i),
        .mepc_o(mepc_o), .mtval_o(mtval_o), .mcause_o(mcause_o), .mpriv_o(mpriv_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        wr_en_i = '0; wr_addr_i = '0; wr_data_i = '0;
        busy_set_i = 0; busy_addr_i = '0;
        exc_en_i = 0; exc_pc_i = '0; exc_tval_i = '0; exc_cause_i = '0;
        mret_i = 0; priv_wr_en_i = 0; priv_wr_data_i = '0;
    endtask

    task automatic exc(input logic [31:0] pc, input logic [31:0] cause);
        exc_en_i = 1; exc_pc_i = pc; exc_cause_i = cause; exc_tval_i = pc ^ 32'h5A5A_0000;
    endtask

    logic [31:0] bp_exp;

    initial begin
        idle();
        rd_addr_i = {5'd3, 5'd5};
        rsn_i = 0;
        #12;
        chk("rst_busy", busy_o, 32'h0);
        chk("rst_mpriv", mpriv_o, 32'h1);
        chk("rst_mepc", mepc_o, 32'h0);
        chk("rst_rd0", rd_data_o[31:0], 32'h0);
        @(negedge clk_i);
        rsn_i = 1;

        // Two writes to x5 in one cycle: port 1 wins.
        wr_en_i = 2'b11; wr_addr_i = {5'd5, 5'd5}; wr_data_i = {32'h22, 32'h11};
        step(); idle();
        rd_addr_i = {5'd5, 5'd5};
        #1;
        chk("wr_conflict_p0", rd_data_o[31:0], 32'h22);
        chk("wr_conflict_p1", rd_data_o[63:32], 32'h22);

        // x0 ignores writes.
        wr_en_i = 2'b01; wr_addr_i = {5'd0, 5'd0}; wr_data_i = {32'h0, 32'hFFFF_FFFF};
        step(); idle();
        rd_addr_i = {5'd5, 5'd0};
        #1;
        chk("x0_zero", rd_data_o[31:0], 32'h0);

        // Set and clear of x7 in one cycle: set wins.
        busy_set_i = 1; busy_addr_i = 5'd7;
        wr_en_i = 2'b10; wr_addr_i = {5'd7, 5'd0}; wr_data_i = {32'h77, 32'h0};
        step(); idle();
        chk("busy_set_wins", busy_o, 32'h0000_0080);
        busy_set_i = 1; busy_addr_i = 5'd9;
        step(); idle();
        chk("busy_x9_set", busy_o, 32'h0000_0280);
        wr_en_i = 2'b01; wr_addr_i = {5'd0, 5'd7}; wr_data_i = {32'h0, 32'h7777};
        step(); idle();
        chk("busy_x7_clr", busy_o, 32'h0000_0200);
        busy_set_i = 1; busy_addr_i = 5'd0;
        step(); idle();
        chk("busy_x0_const", busy_o, 32'h0000_0200);

        // Exceptions: mepc adjust and flush.
        exc(32'h100, 32'h1000);
        wr_en_i = 2'b01; wr_addr_i = {5'd0, 5'd12}; wr_data_i = {32'h0, 32'h55};
        step(); idle();
        chk("mepc_keep_b12", mepc_o, 32'h100);
        chk("mcause_load", mcause_o, 32'h1000);
        chk("mtval_load", mtval_o, 32'h5A5A_0100);
        chk("exc_flush", busy_o, 32'h0);
        rd_addr_i = {5'd7, 5'd12};
        #1;
        chk("exc_gpr_wr", rd_data_o[31:0], 32'h55);
        chk("x7_val", rd_data_o[63:32], 32'h7777);
        exc(32'h100, 32'h2);
        step(); idle();
        chk("mepc_plus4", mepc_o, 32'h104);
        chk("exc_mpriv", mpriv_o, 32'h1);
        exc(32'h200, 32'h8000);
        step(); idle();
        chk("mepc_keep_b15", mepc_o, 32'h200);
        exc(32'hFFFF_FFFC, 32'h5);
        step(); idle();
        chk("mepc_wrap", mepc_o, 32'h0);

        // Privilege stack: priv_wr 0, exc, mret -> 0,1,0.
        priv_wr_en_i = 1; priv_wr_data_i = 32'h0;
        step(); idle();
        chk("priv_wr", mpriv_o, 32'h0);
        exc(32'h300, 32'h2);
        step(); idle();
        chk("priv_exc", mpriv_o, 32'h1);
        mret_i = 1;
        step(); idle();
        chk("priv_mret", mpriv_o, 32'h0);
        exc(32'h400, 32'h2); mret_i = 1;
        step(); idle();
        chk("exc_over_mret", mpriv_o, 32'h1);
        // mpp now 0 (pushed from mpriv 0); mret beats priv_wr.
        mret_i = 1; priv_wr_en_i = 1; priv_wr_data_i = 32'h3;
        step(); idle();
        chk("mret_over_privwr", mpriv_o, 32'h0);

        // Forwarding: x3 holds 0x77, then write 0xAB while reading it.
        wr_en_i = 2'b01; wr_addr_i = {5'd0, 5'd3}; wr_data_i = {32'h0, 32'h77};
        step(); idle();
        rd_addr_i = {5'd0, 5'd3};
        wr_en_i = 2'b10; wr_addr_i = {5'd3, 5'd0}; wr_data_i = {32'hAB, 32'h0};
`ifdef INT_RF_BYPASS_EN
        bp_exp = 32'hAB;
`else
        bp_exp = 32'h77;
`endif
        #1;
        chk("bypass_same_cycle", rd_data_o[31:0], bp_exp);
        step(); idle();
        chk("bypass_next_cycle", rd_data_o[31:0], 32'hAB);

        // Reset asserted mid-cycle while a write is in flight.
        rd_addr_i = {5'd3, 5'd5};
        wr_en_i = 2'b01; wr_addr_i = {5'd0, 5'd4}; wr_data_i = {32'h0, 32'h99};
        #2;
        rsn_i = 0;
        #1;
        chk("rst_async_x5", rd_data_o[31:0], 32'h0);
        chk("rst_async_x3", rd_data_o[63:32], 32'h0);
        chk("rst_async_mpriv", mpriv_o, 32'h1);
        step();
        idle();
        chk("rst_hold_mepc", mepc_o, 32'h0);
        #3;
        rsn_i = 1;
        rd_addr_i = {5'd12, 5'd4};
        step();
        chk("rst_drop_wr_x4", rd_data_o[31:0], 32'h0);
        chk("rst_x12", rd_data_o[63:32], 32'h0);
        chk("rst_busy_after", busy_o, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
